// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (hsync/vsync/video_on/x/y/strobes) gated by a settled PLL lock.
// Outputs are registered from the internal counters and forced to idle levels outside RUN.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   LOCK_WAIT = 1024,
    parameter int   CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SET_W   = $clog2(LOCK_WAIT + 1);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_WAIT - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] SETTLE    = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    logic             lock_m, lock_s;
    logic [1:0]       state, state_nx;
    logic [SET_W-1:0] settle_cnt;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, h_wrap, v_wrap;

    // Gating with lock_s makes the edge that sees lock loss already produce idle outputs.
    assign active = (state == RUN) && lock_s;
    assign h_wrap = h_cnt == H_LAST;
    assign v_wrap = v_cnt == V_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT_LOCK: state_nx = lock_s ? SETTLE : WAIT_LOCK;
            SETTLE:    state_nx = !lock_s ? WAIT_LOCK : (settle_cnt == SET_LAST) ? RUN : SETTLE;
            RUN:       state_nx = lock_s ? RUN : WAIT_LOCK;
            default:   state_nx = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == SETTLE && lock_s && settle_cnt != SET_LAST) ? settle_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (active) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            v_cnt <= !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else if (active) begin
            hsync       <= (h_cnt >= HS_LO && h_cnt <= HS_HI) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_cnt >= VS_LO && v_cnt <= VS_HI) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= h_cnt == '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            running     <= 1'b1;
        end else begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of lock settling, raster timing, lock loss and async reset.
// Vertical timing is shrunk to 10 lines (4/2/2/2) so a whole frame is 8000 clks.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       hsync, vsync, video_on, line_start, frame_start, running;
    logic [9:0] x, y;
    int         errors = 0;
    int         checks = 0;

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .LOCK_WAIT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge 0 is the first posedge sampling pll_locked; returns the edge index of the first frame_start.
    task automatic wait_fs(output int n);
        n = -1;
        @(posedge clk);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_start) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_run"}, running, 0);
        chk({tag, "_xy"}, {x, y}, 0);
        chk({tag, "_sync"}, {hsync, vsync}, 2'b11);
        chk({tag, "_vid_strobes"}, {video_on, line_start, frame_start}, 0);
    endtask

    initial begin
        int n, hx, vy, mism, vid0, hs0, hs_first, hs_last, vs_low, ls_n, fs_n;
        logic e_vid, e_hs, e_vs;
        pll_locked = 1'b1;
        #22;
        chk_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;
        wait_fs(n);
        chk("first_fs_latency", n, 19);
        chk("first_fs_run_xy", {running, x, y}, {1'b1, 20'd0});

        mism = 0; vid0 = 0; hs0 = 0; hs_first = -1; hs_last = -1; vs_low = 0; ls_n = 0; fs_n = 0;
        for (int c = 0; c <= 8000; c++) begin
            if (c > 0) @(negedge clk);
            hx = c % 800;
            vy = (c / 800) % 10;
            e_vid = hx < 640 && vy < 4;
            e_hs = !(hx >= 656 && hx <= 751);
            e_vs = !(vy >= 6 && vy <= 7);
            if ({x, y, video_on, hsync, vsync, line_start, frame_start, running} !==
                {10'(hx), 10'(vy), e_vid, e_hs, e_vs, hx == 0, hx == 0 && vy == 0, 1'b1})
                mism++;
            if (c < 800) begin
                vid0 += int'(video_on);
                if (!hsync) begin
                    hs0++;
                    if (hs_first < 0) hs_first = int'(x);
                    hs_last = int'(x);
                end
            end
            if (c < 8000) begin
                vs_low += int'(!vsync);
                ls_n += int'(line_start);
                fs_n += int'(frame_start);
            end
            if (c == 7999) chk("wrap_before_xy", {x, y}, {10'd799, 10'd9});
        end
        chk("raster_model_mismatches", mism, 0);
        chk("line0_video_clks", vid0, 640);
        chk("line0_hsync_low_clks", hs0, 96);
        chk("hsync_first_x", hs_first, 656);
        chk("hsync_last_x", hs_last, 751);
        chk("vsync_low_clks", vs_low, 1600);
        chk("line_start_per_frame", ls_n, 10);
        chk("frame_start_per_frame", fs_n, 1);
        chk("wrap_after_fs_xy", {frame_start, x, y}, {1'b1, 20'd0});

        for (int i = 0; i < 20000 && !(x == 300 && y == 2); i++) @(negedge clk);
        chk("reach_x300_y2", {x, y}, {10'd300, 10'd2});
        pll_locked = 1'b0;
        n = -1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (!running) begin
                n = i;
                break;
            end
        end
        chk("lock_loss_within_3", n >= 1 && n <= 3, 1);
        chk_idle("lock_loss");
        repeat (5) @(negedge clk);
        chk("stays_idle_unlocked", running, 0);
        pll_locked = 1'b1;
        wait_fs(n);
        chk("relock_fs_latency", n, 19);
        chk("relock_xy", {x, y}, 0);

        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_glitch_idle", running, 0);
        pll_locked = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_settle_not_running", running, 0);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_fs(n);
        chk("glitch_relock_latency", n, 19);

        for (int i = 0; i < 1000 && x != 100; i++) @(negedge clk);
        chk("pre_reset_video", {running, video_on, x}, {1'b1, 1'b1, 10'd100});
        #2 reset_n = 1'b0;
        #1;
        chk_idle("async_reset");
        #20 reset_n = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
